// File: rtl/nbbpu_run_monitor.sv
// Run controller beside the nbbpu core: reset sequencing, cycle/write counters, halt/timeout detect, trace ring.
// Status outputs registered (one-edge latency); trace read combinational; no backpressure, inputs sampled every RUN edge.
module nbbpu_run_monitor #(
  parameter int PC_WIDTH     = 16,
  parameter int INSTR_WIDTH  = 16,
  parameter int COUNT_WIDTH  = 16,
  parameter int RESET_CYCLES = 2,
  parameter int CYCLE_LIMIT  = 24,
  parameter int HALT_REPEAT  = 2,
  parameter int TRACE_DEPTH  = 8,
  parameter int TRACE_AW     = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   write_enable,
  output logic                   cpu_reset,
  output logic                   cpu_clock_enable,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] write_count,
  output logic [1:0]             state,
  output logic                   halted,
  output logic                   timeout,
  input  logic [TRACE_AW-1:0]    trace_index,
  output logic [PC_WIDTH-1:0]    trace_pc,
  output logic [INSTR_WIDTH-1:0] trace_instruction,
  output logic [TRACE_AW:0]      trace_fill
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_t;

  localparam int FW = TRACE_AW + 1;
  localparam logic [7:0]             HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [3:0]             HALT_N    = 4'(HALT_REPEAT);
  localparam logic [COUNT_WIDTH-1:0] LIMIT_C   = COUNT_WIDTH'(CYCLE_LIMIT);
  localparam logic [COUNT_WIDTH-1:0] ONE_C     = COUNT_WIDTH'(1);
  localparam logic [FW-1:0]          FILL_MAX  = FW'(TRACE_DEPTH);
  localparam logic [FW-1:0]          ONE_F     = FW'(1);
  localparam logic [TRACE_AW-1:0]    ONE_A     = TRACE_AW'(1);

  run_state_t state_q, state_d;

  logic [7:0]             hold_cnt;
  logic [3:0]             rep_cnt, rep_next;
  logic                   prev_vld;
  logic [PC_WIDTH-1:0]    prev_pc;
  logic [TRACE_AW-1:0]    wr_ptr, rd_slot;
  logic [COUNT_WIDTH-1:0] cycle_next;
  logic                   hold_done, halt_hit, limit_hit, restart_ok;

  logic [PC_WIDTH-1:0]    trace_pc_mem    [TRACE_DEPTH];
  logic [INSTR_WIDTH-1:0] trace_instr_mem [TRACE_DEPTH];

  // prev_vld suppresses the PC comparison on the first RUN edge after (re)start.
  always_comb begin
    cycle_next = (cycle_count == '1) ? cycle_count : cycle_count + ONE_C;
    rep_next   = '0;
    if (prev_vld && (pc == prev_pc)) begin
      rep_next = (rep_cnt == '1) ? rep_cnt : rep_cnt + 4'd1;
    end
    hold_done  = (hold_cnt == HOLD_LAST);
    halt_hit   = (rep_next == HALT_N);
    limit_hit  = (CYCLE_LIMIT != 0) && (cycle_next == LIMIT_C);
    restart_ok = restart && ((state_q == ST_HALTED) || (state_q == ST_TIMEOUT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt is checked before timeout so a coincident halt wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_hit)       state_d = ST_HALTED;
        else if (limit_hit) state_d = ST_TIMEOUT;
      end
      default: begin
        if (restart) state_d = ST_HOLD;
      end
    endcase
  end

  always_comb begin
    state            = state_q;
    cpu_reset        = (state_q == ST_HOLD);
    cpu_clock_enable = (state_q == ST_RUN);
    halted           = (state_q == ST_HALTED);
    timeout          = (state_q == ST_TIMEOUT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt    <= '0;
      cycle_count <= '0;
      write_count <= '0;
      trace_fill  <= '0;
      wr_ptr      <= '0;
      rep_cnt     <= '0;
      prev_vld    <= 1'b0;
      prev_pc     <= '0;
    end else if (restart_ok) begin
      hold_cnt    <= '0;
      cycle_count <= '0;
      write_count <= '0;
      trace_fill  <= '0;
      wr_ptr      <= '0;
      rep_cnt     <= '0;
      prev_vld    <= 1'b0;
      prev_pc     <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
        end
        ST_RUN: begin
          cycle_count <= cycle_next;
          if (write_enable && (write_count != '1)) write_count <= write_count + ONE_C;
          wr_ptr <= wr_ptr + ONE_A;
          if (trace_fill != FILL_MAX) trace_fill <= trace_fill + ONE_F;
          prev_pc  <= pc;
          prev_vld <= 1'b1;
          rep_cnt  <= rep_next;
        end
        default: begin
        end
      endcase
    end
  end

  // Trace storage carries no reset; trace_fill masks stale slots on readout.
  always_ff @(posedge clock) begin
    if (state_q == ST_RUN) begin
      trace_pc_mem[wr_ptr]    <= pc;
      trace_instr_mem[wr_ptr] <= instruction;
    end
  end

  always_comb begin
    rd_slot           = wr_ptr - ONE_A - trace_index;
    trace_pc          = '0;
    trace_instruction = '0;
    if ({1'b0, trace_index} < trace_fill) begin
      trace_pc          = trace_pc_mem[rd_slot];
      trace_instruction = trace_instr_mem[rd_slot];
    end
  end

endmodule

// File: tb/tb_nbbpu_run_monitor.sv
// Self-checking bench for nbbpu_run_monitor: vector table for the halt run, scoreboarded step sequences elsewhere.
`timescale 1ns/1ps
module tb_nbbpu_run_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] instruction = '0;
  logic        write_enable = 1'b0;
  logic [2:0]  trace_index = '0;
  logic        cpu_reset, cpu_clock_enable, halted, timeout;
  logic [15:0] cycle_count, write_count, trace_pc, trace_instruction;
  logic [1:0]  state;
  logic [3:0]  trace_fill;

  nbbpu_run_monitor #(
    .PC_WIDTH(16), .INSTR_WIDTH(16), .COUNT_WIDTH(16), .RESET_CYCLES(2),
    .CYCLE_LIMIT(24), .HALT_REPEAT(2), .TRACE_DEPTH(8), .TRACE_AW(3)
  ) dut (
    .clock(clock), .reset(reset), .restart(restart), .pc(pc),
    .instruction(instruction), .write_enable(write_enable),
    .cpu_reset(cpu_reset), .cpu_clock_enable(cpu_clock_enable),
    .cycle_count(cycle_count), .write_count(write_count), .state(state),
    .halted(halted), .timeout(timeout), .trace_index(trace_index),
    .trace_pc(trace_pc), .trace_instruction(trace_instruction),
    .trace_fill(trace_fill)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] cyc;
    logic [15:0] wr;
    logic [3:0]  fill;
  } exp_t;

  typedef struct {
    logic [15:0] pc;
    logic        we;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk_exp(input int st, input int cyc, input int wr, input int fill);
    exp_t e;
    e.st = 2'(st); e.cyc = 16'(cyc); e.wr = 16'(wr); e.fill = 4'(fill);
    return e;
  endfunction

  function automatic vec_t mk_vec(input int p, input int we, input int st, input int cyc,
                                  input int wr, input int fill);
    vec_t v;
    v.pc = 16'(p); v.we = 1'(we); v.e = mk_exp(st, cyc, wr, fill);
    return v;
  endfunction

  function automatic logic [15:0] instr_of(input logic [15:0] p);
    return p ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string tag);
    chk($sformatf("%s state", tag), 32'(state), 32'(e.st));
    chk($sformatf("%s cycle_count", tag), 32'(cycle_count), 32'(e.cyc));
    chk($sformatf("%s write_count", tag), 32'(write_count), 32'(e.wr));
    chk($sformatf("%s trace_fill", tag), 32'(trace_fill), 32'(e.fill));
    chk($sformatf("%s cpu_reset", tag), 32'(cpu_reset), 32'(e.st == 2'd0));
    chk($sformatf("%s cpu_clock_enable", tag), 32'(cpu_clock_enable), 32'(e.st == 2'd1));
    chk($sformatf("%s halted", tag), 32'(halted), 32'(e.st == 2'd2));
    chk($sformatf("%s timeout", tag), 32'(timeout), 32'(e.st == 2'd3));
  endtask

  // Drive one cycle of inputs, queue its expectation, compare #1 after the edge.
  task automatic step(input logic [15:0] p, input logic we, input logic rs, input exp_t e,
                      input string tag);
    pc = p; instruction = instr_of(p); write_enable = we; restart = rs;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    restart = 1'b0;
    if (exp_q.size() == 0) begin
      chk($sformatf("%s scoreboard empty", tag), 32'd0, 32'd1);
    end else begin
      check_outputs(exp_q.pop_front(), tag);
    end
  endtask

  task automatic chk_trace(input logic [2:0] idx, input logic [15:0] exp_pc, input logic valid,
                           input string tag);
    trace_index = idx;
    #1;
    chk($sformatf("%s trace_pc[%0d]", tag, idx), 32'(trace_pc), 32'(exp_pc));
    chk($sformatf("%s trace_instruction[%0d]", tag, idx), 32'(trace_instruction),
        valid ? 32'(instr_of(exp_pc)) : 32'd0);
  endtask

  task automatic restart_seq(input string tag);
    step(16'd0, 1'b0, 1'b1, mk_exp(0, 0, 0, 0), {tag, " restart"});
    step(16'd0, 1'b0, 1'b0, mk_exp(0, 0, 0, 0), {tag, " hold1"});
    step(16'd0, 1'b0, 1'b0, mk_exp(1, 0, 0, 0), {tag, " hold2"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within 100000 ns");
    $fatal(1);
  end

  vec_t halt_tab[6];

  initial begin
    int wr_exp;
    halt_tab[0] = mk_vec(0, 1, 1, 1, 1, 1);
    halt_tab[1] = mk_vec(1, 0, 1, 2, 1, 2);
    halt_tab[2] = mk_vec(2, 1, 1, 3, 2, 3);
    halt_tab[3] = mk_vec(3, 0, 1, 4, 2, 4);
    halt_tab[4] = mk_vec(3, 0, 1, 5, 2, 5);
    halt_tab[5] = mk_vec(3, 1, 2, 6, 3, 6);

    // Reset values, then exactly two hold edges before RUN.
    #20;
    check_outputs(mk_exp(0, 0, 0, 0), "reset");
    #2 reset = 1'b1;
    step(16'd7, 1'b1, 1'b0, mk_exp(0, 0, 0, 0), "hold edge1");
    step(16'd7, 1'b1, 1'b0, mk_exp(1, 0, 0, 0), "hold edge2");

    for (int i = 0; i < 6; i++) begin
      step(halt_tab[i].pc, halt_tab[i].we, 1'b0, halt_tab[i].e, $sformatf("halt[%0d]", i));
    end
    step(16'd9, 1'b1, 1'b0, mk_exp(2, 6, 3, 6), "halted frozen");
    chk_trace(3'd0, 16'd3, 1'b1, "halt");
    chk_trace(3'd2, 16'd3, 1'b1, "halt");
    chk_trace(3'd3, 16'd2, 1'b1, "halt");
    chk_trace(3'd5, 16'd0, 1'b1, "halt");
    chk_trace(3'd6, 16'd0, 1'b0, "halt");

    // Wrap: 11 RUN cycles, three writes, a restart pulse that RUN must ignore.
    restart_seq("r1");
    wr_exp = 0;
    for (int i = 0; i < 11; i++) begin
      logic we;
      we = (i == 2) || (i == 5) || (i == 9);
      if (we) wr_exp++;
      step(16'(100 + i), we, 1'(i == 4), mk_exp(1, i + 1, wr_exp, (i + 1 > 8) ? 8 : i + 1),
           $sformatf("wrap[%0d]", i));
    end
    chk_trace(3'd0, 16'd110, 1'b1, "wrap");
    chk_trace(3'd4, 16'd106, 1'b1, "wrap");
    chk_trace(3'd7, 16'd103, 1'b1, "wrap");

    // Keep going to the cycle limit.
    for (int i = 11; i < 24; i++) begin
      step(16'(100 + i), 1'b0, 1'b0, mk_exp((i == 23) ? 3 : 1, i + 1, 3, 8),
           $sformatf("limit[%0d]", i));
    end
    step(16'd5, 1'b1, 1'b0, mk_exp(3, 24, 3, 8), "timeout frozen");
    chk_trace(3'd0, 16'd123, 1'b1, "timeout");

    // Halt and limit on the same edge: halt takes priority.
    restart_seq("r2");
    for (int i = 0; i < 24; i++) begin
      step((i < 21) ? 16'(200 + i) : 16'd300, 1'b0, 1'b0,
           mk_exp((i == 23) ? 2 : 1, i + 1, 0, (i + 1 > 8) ? 8 : i + 1),
           $sformatf("both[%0d]", i));
    end

    // Reset dropped between edges while running.
    restart_seq("r3");
    for (int i = 0; i < 3; i++) begin
      step(16'(400 + i), 1'b1, 1'b0, mk_exp(1, i + 1, i + 1, i + 1), $sformatf("pre_rst[%0d]", i));
    end
    #2 reset = 1'b0;
    #1;
    check_outputs(mk_exp(0, 0, 0, 0), "async reset");
    #5 reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nbbpu_run_monitor.md
Name: nbbpu_run_monitor

Overview:
- Synthesizable run controller and execution monitor placed beside the nbbpu core, between board reset and the core's reset pin.
- Sequences core reset release and gates the core clock enable.
- Counts cycles and data-memory writes, detects halt (PC stuck) and timeout (cycle limit), and keeps a circular trace of the most recent {PC, instruction} pairs for debug readout.

Parameters:
- PC_WIDTH, 16, width of the core program counter.
- INSTR_WIDTH, 16, width of the instruction word.
- COUNT_WIDTH, 16, width of the cycle and write counters.
- RESET_CYCLES, 2, clock edges `cpu_reset` stays asserted after `reset` deasserts (range 1..255).
- CYCLE_LIMIT, 24, RUN cycles before timeout; 0 disables timeout.
- HALT_REPEAT, 2, consecutive RUN cycles with an unchanged PC that declare a halt (range 1..15).
- TRACE_DEPTH, 8, trace buffer entries (power of 2, at least 2).
- TRACE_AW, 3, trace index width (log2 of TRACE_DEPTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- restart  in  1  single-cycle pulse; from HALTED or TIMEOUT, re-enters RESET_HOLD.
- pc  in  PC_WIDTH  core program counter.
- instruction  in  INSTR_WIDTH  instruction currently fetched by the core.
- write_enable  in  1  core data-memory write strobe.
- cpu_reset  out  1  active-high reset to the core.
- cpu_clock_enable  out  1  core advance enable.
- cycle_count  out  COUNT_WIDTH  RUN cycles elapsed.
- write_count  out  COUNT_WIDTH  RUN cycles with write_enable high.
- state  out  2  0=RESET_HOLD, 1=RUN, 2=HALTED, 3=TIMEOUT.
- halted  out  1  high while state is HALTED.
- timeout  out  1  high while state is TIMEOUT.
- trace_index  in  TRACE_AW  trace slot to read; 0 is the most recent.
- trace_pc  out  PC_WIDTH  PC stored at trace_index.
- trace_instruction  out  INSTR_WIDTH  instruction stored at trace_index.
- trace_fill  out  TRACE_AW+1  number of valid trace entries (0..TRACE_DEPTH).

Behaviour:
- Reset low, applied asynchronously:
  - state=RESET_HOLD, cpu_reset=1, cpu_clock_enable=0.
  - All counters, trace_fill, write pointer and halt-repeat counter cleared to 0.
  - trace storage contents are don't-care.
- RESET_HOLD:
  - A hold counter runs from the first rising edge with reset high.
  - After RESET_CYCLES edges, state goes to RUN. On that same edge cpu_reset becomes 0 and cpu_clock_enable becomes 1.
- RUN, on each edge:
  - cycle_count increments, saturating at all-ones.
  - write_count increments if write_enable=1.
  - {pc, instruction} is written at the write pointer. The pointer increments modulo TRACE_DEPTH (wraps, overwriting the oldest entry).
  - trace_fill increments, saturating at TRACE_DEPTH.
- Halt detect:
  - A registered previous PC is loaded on every RUN edge.
  - On the first RUN edge no comparison is made.
  - If pc equals the previous PC, the repeat counter increments; otherwise it clears.
  - When the counter reaches HALT_REPEAT, state goes to HALTED on that edge.
- Timeout:
  - If CYCLE_LIMIT != 0 and cycle_count reaches CYCLE_LIMIT on this edge, state goes to TIMEOUT.
- Simultaneous halt and timeout on the same edge: HALTED wins. timeout stays 0.
- HALTED / TIMEOUT:
  - cpu_clock_enable=0 and cpu_reset=0 (core state preserved for inspection).
  - Counters and trace are frozen.
  - Inputs other than restart and trace_index are ignored.
- restart:
  - Honoured only in HALTED or TIMEOUT; ignored in RESET_HOLD and RUN.
  - On the edge it is seen: state goes to RESET_HOLD, cpu_reset=1, cpu_clock_enable=0.
  - Counters, trace_fill, pointer, repeat counter and hold counter are cleared.
- Trace read:
  - Combinational from trace_index.
  - Physical slot is (write_pointer - 1 - trace_index) mod TRACE_DEPTH.
  - If trace_index >= trace_fill, trace_pc and trace_instruction read 0.
- Reset asserted mid-RUN: immediate return to the reset values above, with no waiting for a clock edge.
- halted and timeout are decoded from state (registered), never combinational from inputs.

Test Plan:
- Reset low 22 ns, then high. cpu_reset is high through exactly 2 rising edges, then cpu_reset=0, cpu_clock_enable=1, state=1.
- PC increments 0,1,2,… and never repeats, CYCLE_LIMIT=24. state=3 and timeout=1 on the 24th RUN edge; cycle_count=24; cpu_clock_enable=0.
- PC sequence 0,1,2,3,3,3. state=2 on the edge after the second repeat (HALT_REPEAT=2); cycle_count=6; trace_index 0..2 read pc 3,3,3 and trace_index 3 reads pc 2.
- Run 11 cycles with TRACE_DEPTH=8. trace_fill=8; trace_index 7 returns the 4th captured PC (wrap); write_enable high on 3 cycles gives write_count=3.
- In TIMEOUT, pulse restart for 1 cycle. state=0, all counters 0, trace_fill=0; after 2 edges RUN resumes and counting restarts from 0.
- Drive reset low mid-RUN between edges. Outputs go to reset values immediately. Restart pulsed during RUN has no effect.
